// File: rtl/imm_arith_exec_ctrl_pkg.sv
// Shared types for the immediate-arithmetic execute step:
// operation kinds, controller state and shift-amount width.
package instr_type;

   typedef enum logic [3:0] {
      iak_invalid = 4'd0,
      iak_addi    = 4'd1,
      iak_slti    = 4'd2,
      iak_sltiu   = 4'd3,
      iak_xori    = 4'd4,
      iak_ori     = 4'd5,
      iak_andi    = 4'd6,
      iak_slli    = 4'd7,
      iak_srli    = 4'd8,
      iak_srai    = 4'd9
   } imm_arith_kind_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } imm_arith_exec_state_t;

   localparam int SHAMT_W = 5;

   function automatic logic is_shift_kind(imm_arith_kind_t k);
      return (k == iak_slli) || (k == iak_srli) || (k == iak_srai);
   endfunction

endpackage

// File: rtl/imm_arith_exec_ctrl_shift.sv
// imm_shift_step: one combinational shifter step.
// Ports: acc (value), amt (bits), kind (slli/srli/srai) -> result.
module imm_shift_step
   import instr_type::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]    acc,
   input  logic [SHAMT_W-1:0] amt,
   input  imm_arith_kind_t    kind,
   output logic [XLEN-1:0]    result
);

   always_comb begin
      result = acc;
      case (kind)
         iak_slli: result = acc << amt;
         iak_srli: result = acc >> amt;
         iak_srai: result = $unsigned($signed(acc) >>> amt);
         default:  result = acc;
      endcase
   end

endmodule

// File: rtl/imm_arith_exec_ctrl.sv
// imm_arith_exec_ctrl: I-type immediate arithmetic execute controller.
// Ports: clk/rst/flush; in_* decode handshake (kind, rs1, imm, rd);
// out_* writeback handshake (result, rd, illegal); busy = not IDLE.
module imm_arith_exec_ctrl
   import instr_type::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  imm_arith_kind_t in_kind,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [11:0]     in_imm,
   input  logic [4:0]      in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            out_illegal,
   output logic            busy
);

   localparam logic [SHAMT_W-1:0] STEP_MAX = SHAMT_W'(SHIFT_STEP);

   imm_arith_exec_state_t state_q;
   imm_arith_kind_t       kind_q;
   logic [XLEN-1:0]       acc_q;
   logic [SHAMT_W-1:0]    rem_q;
   logic [XLEN-1:0]       res_q;
   logic [4:0]            rd_q;
   logic                  ill_q;

   logic [XLEN-1:0]    imm_sx;
   logic [SHAMT_W-1:0] shamt;
   logic [SHAMT_W-1:0] step;
   logic [XLEN-1:0]    shifted;
   logic [XLEN-1:0]    alu_res;
   logic               accept;
   logic               go_shift;

   assign imm_sx = {{(XLEN-12){in_imm[11]}}, in_imm};
   assign shamt  = in_imm[SHAMT_W-1:0];

   assign in_ready = ~flush &
                     ((state_q == IDLE) |
                      ((state_q == DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   // Zero-amount shifts complete like single-cycle ops.
   assign go_shift = is_shift_kind(in_kind) & (shamt != '0);

   assign step = (rem_q < STEP_MAX) ? rem_q : STEP_MAX;

   always_comb begin
      alu_res = '0;
      case (in_kind)
         iak_addi:  alu_res = in_rs1 + imm_sx;
         iak_slti:  alu_res = {{(XLEN-1){1'b0}},
                               $signed(in_rs1) < $signed(imm_sx)};
         iak_sltiu: alu_res = {{(XLEN-1){1'b0}}, in_rs1 < imm_sx};
         iak_xori:  alu_res = in_rs1 ^ imm_sx;
         iak_ori:   alu_res = in_rs1 | imm_sx;
         iak_andi:  alu_res = in_rs1 & imm_sx;
         iak_slli,
         iak_srli,
         iak_srai:  alu_res = in_rs1;
         default:   alu_res = '0;
      endcase
   end

   imm_shift_step #(
      .XLEN(XLEN)
   ) u_shift (
      .acc    (acc_q),
      .amt    (step),
      .kind   (kind_q),
      .result (shifted)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         kind_q  <= iak_invalid;
         acc_q   <= '0;
         rem_q   <= '0;
         res_q   <= '0;
         rd_q    <= '0;
         ill_q   <= 1'b0;
      end else if (flush) begin
         state_q <= IDLE;
         kind_q  <= iak_invalid;
         acc_q   <= '0;
         rem_q   <= '0;
         res_q   <= '0;
         rd_q    <= '0;
         ill_q   <= 1'b0;
      end else if (accept) begin
         kind_q <= in_kind;
         rd_q   <= in_rd;
         ill_q  <= (in_kind == iak_invalid);
         if (go_shift) begin
            acc_q   <= in_rs1;
            rem_q   <= shamt;
            res_q   <= '0;
            state_q <= SHIFT;
         end else begin
            res_q   <= alu_res;
            state_q <= DONE;
         end
      end else begin
         unique case (1'b1)
            (state_q == SHIFT): begin
               acc_q <= shifted;
               rem_q <= rem_q - step;
               if (rem_q == step) begin
                  res_q   <= shifted;
                  state_q <= DONE;
               end
            end
            (state_q == DONE): begin
               if (out_ready) state_q <= IDLE;
            end
            default: ;
         endcase
      end
   end

   assign out_valid   = (state_q == DONE);
   assign out_result  = res_q;
   assign out_rd      = rd_q;
   assign out_illegal = ill_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_imm_arith_exec_ctrl.sv
// Directed self-checking bench for imm_arith_exec_ctrl
// (SHIFT_STEP=1), hand-computed expected values.
module tb_imm_arith_exec_ctrl;
   import instr_type::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   imm_arith_kind_t in_kind;
   logic [31:0]     in_rs1;
   logic [11:0]     in_imm;
   logic [4:0]      in_rd;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_result;
   logic [4:0]      out_rd;
   logic            out_illegal;
   logic            busy;

   int tests = 0;
   int fails = 0;
   int n;
   logic seen;

   always #5 clk = ~clk;

   imm_arith_exec_ctrl #(
      .XLEN(32),
      .SHIFT_STEP(1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_kind     (in_kind),
      .in_rs1      (in_rs1),
      .in_imm      (in_imm),
      .in_rd       (in_rd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .out_illegal (out_illegal),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, need %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input imm_arith_kind_t k, input logic [31:0] r,
                        input logic [11:0] i, input logic [4:0] d);
      in_valid = 1'b1;
      in_kind  = k;
      in_rs1   = r;
      in_imm   = i;
      in_rd    = d;
   endtask

   // Counts edges from accept until out_valid, bounded.
   task automatic wait_valid(output int cnt);
      cnt = 0;
      do begin
         tick();
         in_valid = 1'b0;
         cnt++;
      end while (!out_valid && cnt < 40);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_kind = iak_addi; in_rs1 = '0; in_imm = '0; in_rd = '0;
      out_ready = 1'b1;
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", out_result, 32'd0);
      chk("rst_rd", 32'(out_rd), 32'd0);
      chk("rst_ill", 32'(out_illegal), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_ready", 32'(in_ready), 32'd1);

      drive(iak_addi, 32'h5, 12'hFFF, 5'd3);
      tick();
      in_valid = 1'b0;
      chk("addi_valid", 32'(out_valid), 32'd1);
      chk("addi_res", out_result, 32'h4);
      chk("addi_rd", 32'(out_rd), 32'd3);
      chk("addi_ill", 32'(out_illegal), 32'd0);

      drive(iak_sltiu, 32'h1, 12'hFFF, 5'd4);
      tick();
      chk("sltiu_res", out_result, 32'h1);
      in_kind = iak_slti;
      tick();
      chk("slti_res0", out_result, 32'h0);
      chk("slti_b2b_valid", 32'(out_valid), 32'd1);
      drive(iak_slti, 32'h8000_0000, 12'h000, 5'd4);
      tick();
      chk("slti_res1", out_result, 32'h1);
      drive(iak_ori, 32'h0000_0F00, 12'h0F0, 5'd8);
      tick();
      chk("ori_res", out_result, 32'h0000_0FF0);
      drive(iak_andi, 32'hFFFF_1234, 12'h800, 5'd8);
      tick();
      chk("andi_res", out_result, 32'hFFFF_1000);
      in_valid = 1'b0;
      tick();
      chk("back_idle", 32'(out_valid), 32'd0);

      drive(iak_slli, 32'h0000_ABCD, 12'h000, 5'd2);
      tick();
      in_valid = 1'b0;
      chk("sh0_valid", 32'(out_valid), 32'd1);
      chk("sh0_res", out_result, 32'h0000_ABCD);
      tick();

      drive(iak_srai, 32'h8000_0000, 12'h41F, 5'd10);
      tick();
      in_valid = 1'b0;
      chk("srai_busy", 32'(busy), 32'd1);
      chk("srai_nvalid", 32'(out_valid), 32'd0);
      in_kind = iak_addi;
      in_rs1  = 32'h0;
      wait_valid(n);
      chk("srai_lat", 32'(n + 1), 32'd32);
      chk("srai_res", out_result, 32'hFFFF_FFFF);
      chk("srai_rd", 32'(out_rd), 32'd10);
      tick();

      drive(iak_srli, 32'h8000_0000, 12'h01F, 5'd11);
      wait_valid(n);
      chk("srli_lat", 32'(n), 32'd32);
      chk("srli_res", out_result, 32'h1);
      tick();

      out_ready = 1'b0;
      drive(iak_addi, 32'h10, 12'h001, 5'd5);
      tick();
      drive(iak_xori, 32'hF0, 12'h0FF, 5'd6);
      chk("bp_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_ready", 32'(in_ready), 32'd0);
         chk("bp_res", out_result, 32'h11);
         tick();
      end
      chk("bp_rd", 32'(out_rd), 32'd5);
      out_ready = 1'b1;
      #1;
      chk("b2b_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_res", out_result, 32'h0F);
      chk("b2b_rd", 32'(out_rd), 32'd6);
      tick();

      drive(iak_slli, 32'h1, 12'h00A, 5'd12);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      flush = 1'b1;
      #1;
      chk("flush_noready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_res", out_result, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      chk("flush_novalid", 32'(seen), 32'd0);
      drive(iak_addi, 32'h7, 12'h002, 5'd9);
      tick();
      in_valid = 1'b0;
      chk("post_flush_res", out_result, 32'h9);
      chk("post_flush_rd", 32'(out_rd), 32'd9);
      tick();

      drive(iak_slli, 32'h1, 12'h00A, 5'd13);
      tick();
      in_valid = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_rd", 32'(out_rd), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      drive(iak_invalid, 32'h1234, 12'h005, 5'd7);
      tick();
      in_valid = 1'b0;
      chk("inv_valid", 32'(out_valid), 32'd1);
      chk("inv_ill", 32'(out_illegal), 32'd1);
      chk("inv_res", out_result, 32'h0);
      chk("inv_rd", 32'(out_rd), 32'd7);
      tick();
      chk("inv_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, need finished");
      $fatal(1, "timeout");
   end

endmodule
